// File: rtl/scramble_sequencer.sv
// Front-end for the GPU command inputs: passes keypad commands through when idle,
// or plays back a pseudo-random sequence of cursor moves and row/column shifts.
module scramble_sequencer #(
    parameter int          NUM_STEPS = 32,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       sysclk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] user_instruction,
    input  logic       user_scramble,
    output logic [3:0] instruction,
    output logic       scramble,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MOVE,
        MOVE_GAP,
        SHIFT,
        SHIFT_GAP,
        DONE
    } state_t;

    localparam logic [15:0] LFSR_MASK  = 16'hB400;
    localparam logic [15:0] LFSR_INIT  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [7:0]  STEP_LIMIT = 8'(NUM_STEPS);

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  step_q, step_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  dir_q, dir_d;
    logic [3:0]  mv_q, mv_d;
    logic [3:0]  instr_q, instr_d;
    logic        scr_q, scr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  dir_w;
    logic [3:0]  cnt_w;
    logic [3:0]  mv_w;
    logic [3:0]  cnt_dec;

    // Free-running so that the moment the user presses start picks the sequence.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    end

    always_comb begin
        dir_w   = {2'b00, lfsr_q[1:0]} + 4'd1;
        cnt_w   = lfsr_q[5:2];
        mv_w    = ((dir_w == 4'd2) || (dir_w == 4'd3)) ? 4'd4 : 4'd2;
        cnt_dec = (cnt_q != 4'd0) ? (cnt_q - 4'd1) : 4'd0;
    end

    // Next-state logic; the *_d output values are what appears while in state_d.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mv_d    = mv_q;
        instr_d = 4'd0;
        scr_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                    step_d  = 8'd0;
                end else begin
                    instr_d = user_instruction;
                    scr_d   = user_scramble;
                end
            end
            LOAD: begin
                dir_d  = dir_w;
                cnt_d  = cnt_w;
                mv_d   = mv_w;
                busy_d = 1'b1;
                if (cnt_w != 4'd0) begin
                    state_d = MOVE;
                    instr_d = mv_w;
                end else begin
                    state_d = SHIFT;
                    instr_d = dir_w;
                    scr_d   = 1'b1;
                end
            end
            MOVE: begin
                state_d = MOVE_GAP;
                busy_d  = 1'b1;
            end
            MOVE_GAP: begin
                cnt_d  = cnt_dec;
                busy_d = 1'b1;
                if (cnt_dec != 4'd0) begin
                    state_d = MOVE;
                    instr_d = mv_q;
                end else begin
                    state_d = SHIFT;
                    instr_d = dir_q;
                    scr_d   = 1'b1;
                end
            end
            SHIFT: begin
                state_d = SHIFT_GAP;
                busy_d  = 1'b1;
            end
            SHIFT_GAP: begin
                step_d = step_q + 8'd1;
                if ((step_q + 8'd1) == STEP_LIMIT) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = LOAD;
                    busy_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort drops any half-finished step; the GPU just sees a quiet cycle.
        if (abort && busy_q) begin
            state_d = DONE;
            instr_d = 4'd0;
            scr_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_INIT;
            step_q  <= 8'd0;
            cnt_q   <= 4'd0;
            dir_q   <= 4'd0;
            mv_q    <= 4'd0;
            instr_q <= 4'd0;
            scr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mv_q    <= mv_d;
            instr_q <= instr_d;
            scr_q   <= scr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign instruction = instr_q;
    assign scramble    = scr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Bench for scramble_sequencer: two instances (32-step and 1-step runs) checked every
// cycle against a queue-based model of the expected GPU command stream.
module tb_scramble_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic [3:0] instr;
        logic       scr;
        logic       busy;
        logic       done;
    } outVec_t;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic       start0, start1, abort0, abort1;
    logic [3:0] userInstr;
    logic       userScr;
    logic [3:0] instr0, instr1;
    logic       scr0, scr1, busy0, busy1, done0, done1;

    int errCount   = 0;
    int checkCount = 0;
    int cycleNo    = 0;

    logic [15:0] modelLfsr;
    outVec_t     expQ [2][$];
    outVec_t     lastExp [2];

    always #5 sysclk = ~sysclk;

    scramble_sequencer #(.NUM_STEPS(32), .LFSR_SEED(SEED)) dut0 (
        .sysclk(sysclk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .user_instruction(userInstr), .user_scramble(userScr),
        .instruction(instr0), .scramble(scr0), .busy(busy0), .done(done0)
    );

    scramble_sequencer #(.NUM_STEPS(1), .LFSR_SEED(SEED)) dut1 (
        .sysclk(sysclk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .user_instruction(userInstr), .user_scramble(userScr),
        .instruction(instr1), .scramble(scr1), .busy(busy1), .done(done1)
    );

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic outVec_t mkVec(input int i, input logic s, input logic b, input logic d);
        outVec_t r;
        r.instr = 4'(i);
        r.scr   = s;
        r.busy  = b;
        r.done  = d;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, want %0h", tag, cycleNo, obs, exp);
        end
    endtask

    // Whole run expanded up front: each step is LOAD, cnt move/gap pairs, shift, gap.
    task automatic buildRun(input int d, input int steps, input logic [15:0] lfsrAtLoad);
        logic [15:0] l;
        int dir, cnt, mv;
        l = lfsrAtLoad;
        expQ[d].delete();
        for (int s = 0; s < steps; s++) begin
            dir = int'(l[1:0]) + 1;
            cnt = int'(l[5:2]);
            mv  = (dir == 2 || dir == 3) ? 4 : 2;
            expQ[d].push_back(mkVec(0, 1'b0, 1'b1, 1'b0));
            l = lfsrNext(l);
            for (int k = 0; k < cnt; k++) begin
                expQ[d].push_back(mkVec(mv, 1'b0, 1'b1, 1'b0));
                expQ[d].push_back(mkVec(0, 1'b0, 1'b1, 1'b0));
                l = lfsrNext(lfsrNext(l));
            end
            expQ[d].push_back(mkVec(dir, 1'b1, 1'b1, 1'b0));
            expQ[d].push_back(mkVec(0, 1'b0, 1'b1, 1'b0));
            l = lfsrNext(lfsrNext(l));
        end
        expQ[d].push_back(mkVec(0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic predict(input int d, input logic st, input logic ab, input logic [3:0] ui,
                           input logic us, input int steps);
        outVec_t e;
        if (lastExp[d].busy && ab) begin
            expQ[d].delete();
            e = mkVec(0, 1'b0, 1'b0, 1'b1);
        end else if (expQ[d].size() > 0) begin
            e = expQ[d].pop_front();
        end else if (lastExp[d].done) begin
            e = mkVec(0, 1'b0, 1'b0, 1'b0);
        end else if (st && !ab) begin
            buildRun(d, steps, modelLfsr);
            e = expQ[d].pop_front();
        end else begin
            e = mkVec(int'(ui), us, 1'b0, 1'b0);
        end
        lastExp[d] = e;
    endtask

    task automatic modelReset();
        modelLfsr = SEED;
        expQ[0].delete();
        expQ[1].delete();
        lastExp[0] = '0;
        lastExp[1] = '0;
    endtask

    task automatic applyStimulus();
        logic s0, s1, a0, a1, us, rn;
        logic [3:0] ui;
        s0 = start0; s1 = start1; a0 = abort0; a1 = abort1; ui = userInstr; us = userScr;
        rn = rst_n;
        @(posedge sysclk);
        if (rn) begin
            modelLfsr = lfsrNext(modelLfsr);
            predict(0, s0, a0, ui, us, 32);
            predict(1, s1, a1, ui, us, 1);
        end
        @(negedge sysclk);
        cycleNo++;
        checkOutput("dut0_outputs", {instr0, scr0, busy0, done0}, lastExp[0]);
        checkOutput("dut1_outputs", {instr1, scr1, busy1, done1}, lastExp[1]);
    endtask

    task automatic randomUser();
        userInstr = 4'($urandom_range(0, 4));
        userScr   = 1'($urandom_range(0, 1));
    endtask

    // Idles until the LFSR value the next LOAD would see matches the pattern.
    task automatic waitForLoad(input logic [5:0] mask, input logic [5:0] value);
        logic [15:0] nxt;
        int n;
        applyStimulus();
        applyStimulus();
        n = 0;
        nxt = lfsrNext(modelLfsr);
        while (((nxt[5:0] & mask) != value) && n < 5000) begin
            randomUser();
            applyStimulus();
            nxt = lfsrNext(modelLfsr);
            n++;
        end
        checkOutput("wait_load_found", 32'(n < 5000), 32'd1);
    endtask

    task automatic runDirected(input string tag, input logic [5:0] pat, input int expLen,
                               input logic [3:0] expI [8], input logic expS [8]);
        logic [3:0] histI [8];
        logic       histS [8];
        int cyc;
        waitForLoad(6'h3F, pat);
        start1 = 1'b1;
        cyc = 1;
        for (int k = 0; k < 8; k++) begin
            histI[k] = 4'hF;
            histS[k] = 1'b1;
        end
        for (int k = 0; k < 20; k++) begin
            applyStimulus();
            start1 = 1'b0;
            cyc++;
            if (k < 8) begin
                histI[k] = instr1;
                histS[k] = scr1;
            end
            if (done1) break;
        end
        checkOutput($sformatf("%s_length", tag), 32'(cyc), 32'(expLen));
        for (int k = 0; k < expLen - 1; k++) begin
            checkOutput($sformatf("%s_instr%0d", tag, k), 32'(histI[k]), 32'(expI[k]));
            checkOutput($sformatf("%s_scr%0d", tag, k), 32'(histS[k]), 32'(expS[k]));
        end
    endtask

    initial begin
        logic [3:0] tblAI [8] = '{4'd0, 4'd4, 4'd0, 4'd4, 4'd0, 4'd2, 4'd0, 4'd0};
        logic       tblAS [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] tblBI [8] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        logic       tblBS [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        int n, moves, scrCount, doneCount;
        logic [3:0] prevInstr;

        rst_n = 1'b1; start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;
        userInstr = 4'd0; userScr = 1'b0;
        modelReset();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_dut0", {instr0, scr0, busy0, done0}, 32'd0);
        checkOutput("reset_dut1", {instr1, scr1, busy1, done1}, 32'd0);
        userInstr = 4'd3; userScr = 1'b1;
        repeat (3) applyStimulus();
        rst_n = 1'b1;

        applyStimulus();
        checkOutput("idle_pass_instr", 32'(instr0), 32'd3);
        checkOutput("idle_pass_scr", 32'(scr0), 32'd1);
        checkOutput("idle_pass_busy", 32'(busy0), 32'd0);

        runDirected("dir2_cnt2", 6'b001001, 9, tblAI, tblAS);
        runDirected("dir1_cnt0", 6'b000000, 5, tblBI, tblBS);

        // Full 32-step run with a stray start pulse in the middle.
        applyStimulus();
        applyStimulus();
        userInstr = 4'd0;
        start0 = 1'b1;
        prevInstr = 4'd0; scrCount = 0; doneCount = 0; n = 0;
        while (n < 3000) begin
            applyStimulus();
            start0 = (n == 40) ? 1'b1 : 1'b0;
            n++;
            if (prevInstr != 4'd0) checkOutput("handshake_gap", 32'(instr0), 32'd0);
            prevInstr = instr0;
            if (scr0 && busy0) scrCount++;
            if (done0) begin
                doneCount++;
                break;
            end
        end
        repeat (3) begin
            applyStimulus();
            if (done0) doneCount++;
            checkOutput("no_restart_busy", 32'(busy0), 32'd0);
        end
        checkOutput("run_shift_count", 32'(scrCount), 32'd32);
        checkOutput("run_done_count", 32'(doneCount), 32'd1);

        // Abort during the third cursor move of a four-move step.
        waitForLoad(6'b111100, 6'b010000);
        start0 = 1'b1;
        applyStimulus();
        start0 = 1'b0;
        moves = 0; n = 0;
        while (moves < 3 && n < 100) begin
            applyStimulus();
            n++;
            if (busy0 && instr0 != 4'd0 && !scr0) moves++;
        end
        checkOutput("abort_third_move", 32'(moves), 32'd3);
        abort0 = 1'b1; userInstr = 4'd2; userScr = 1'b1;
        applyStimulus();
        abort0 = 1'b0;
        checkOutput("abort_instr", 32'(instr0), 32'd0);
        checkOutput("abort_done", 32'(done0), 32'd1);
        checkOutput("abort_busy", 32'(busy0), 32'd0);
        applyStimulus();
        checkOutput("abort_after_done", 32'(done0), 32'd0);
        applyStimulus();
        checkOutput("abort_pass_instr", 32'(instr0), 32'd2);
        checkOutput("abort_pass_scr", 32'(scr0), 32'd1);

        // Reset in the middle of a SHIFT, with start pulsed while busy beforehand.
        userInstr = 4'd0; userScr = 1'b0;
        applyStimulus();
        start0 = 1'b1;
        applyStimulus();
        start0 = 1'b0;
        n = 0;
        while (!scr0 && n < 2000) begin
            start0 = (n == 2) ? 1'b1 : 1'b0;
            applyStimulus();
            n++;
        end
        start0 = 1'b0;
        checkOutput("reach_shift", 32'(scr0), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrun_reset_dut0", {instr0, scr0, busy0, done0}, 32'd0);
        checkOutput("midrun_reset_dut1", {instr1, scr1, busy1, done1}, 32'd0);
        modelReset();
        repeat (2) applyStimulus();
        rst_n = 1'b1;
        start0 = 1'b1;
        applyStimulus();
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 3000) begin
            applyStimulus();
            n++;
        end
        checkOutput("post_reset_run_done", 32'(done0), 32'd1);

        // Random traffic on both instances.
        for (int i = 0; i < 4000; i++) begin
            randomUser();
            start0 = ($urandom_range(0, 39) == 0);
            start1 = ($urandom_range(0, 14) == 0);
            abort0 = ($urandom_range(0, 149) == 0);
            abort1 = ($urandom_range(0, 49) == 0);
            applyStimulus();
        end
        start0 = 1'b0; start1 = 1'b0; abort0 = 1'b0; abort1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
